// File: rtl/ide_pio_sequencer_if.sv
// Bus-side bundle for the IDE PIO sequencer: 68k bus qualifiers in, IDE drive controls out.
// The sequencer connects through the slave modport; the bus logic (or a bench) uses master.
interface ide_pio_sequencer_if;
   logic        ide_access;
   logic        ide_enable;
   logic        AS_n;
   logic        UDS_n;
   logic        LDS_n;
   logic        RW;
   logic [16:12] ADDR;
   logic [1:0]  IDE1_CS_n;
   logic [1:0]  IDE2_CS_n;
   logic        IOR_n;
   logic        IOW_n;
   logic        IDE_ROMEN;
   logic        AS_n_S4;
   logic        DTACK;

   modport master (
      output ide_access, ide_enable, AS_n, UDS_n, LDS_n, RW, ADDR,
      input  IDE1_CS_n, IDE2_CS_n, IOR_n, IOW_n, IDE_ROMEN, AS_n_S4, DTACK
   );

   modport slave (
      input  ide_access, ide_enable, AS_n, UDS_n, LDS_n, RW, ADDR,
      output IDE1_CS_n, IDE2_CS_n, IOR_n, IOW_n, IDE_ROMEN, AS_n_S4, DTACK
   );
endinterface

// File: rtl/ide_pio_sequencer.sv
// IDE PIO cycle sequencer: turns a synchronised 68k bus cycle into timed CS / IOR / IOW
// pulses on the drive, or a boot-ROM enable, and requests DTACK back to the bus logic.
module ide_pio_sequencer #(
   parameter int unsigned T_SETUP   = 1,
   parameter int unsigned T_ACTIVE  = 3,
   parameter int unsigned T_RECOVER = 1
) (
   input logic                CLK,
   input logic                RESET_n,
   ide_pio_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_ACTIVE  = 3'd2,
      S_RECOVER = 3'd3,
      S_ROM     = 3'd4,
      S_WAIT_AS = 3'd5
   } state_t;

   localparam logic [2:0] C_SETUP   = 3'(T_SETUP - 1);
   localparam logic [2:0] C_ACTIVE  = 3'(T_ACTIVE - 1);
   localparam logic [2:0] C_RECOVER = 3'(T_RECOVER - 1);

   logic       r_as_s1;
   logic       r_as_s2;
   logic       r_as_s4;
   logic       w_as_s;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic [2:0] w_cnt_dec;
   logic [1:0] r_sel;
   logic [1:0] w_sel_nxt;
   logic       r_rw;
   logic       w_rw_nxt;
   logic       w_start;

   logic [1:0] r_ide1_cs_n;
   logic [1:0] r_ide2_cs_n;
   logic       r_ior_n;
   logic       r_iow_n;
   logic       r_romen;
   logic       r_dtack;
   logic [1:0] w_ide1_cs_n;
   logic [1:0] w_ide2_cs_n;
   logic [1:0] w_cs_pat;
   logic       w_ior_n;
   logic       w_iow_n;
   logic       w_romen;
   logic       w_dtack;

   // AS_n is asynchronous to CLK; every FSM decision looks only at the second flop.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         r_as_s1 <= 1'b1;
         r_as_s2 <= 1'b1;
         r_as_s4 <= 1'b1;
      end else begin
         r_as_s1 <= bus.AS_n;
         r_as_s2 <= r_as_s1;
         r_as_s4 <= r_as_s2;
      end
   end

   assign w_as_s    = r_as_s2;
   assign w_start   = bus.ide_enable && bus.ide_access && !w_as_s && (!bus.UDS_n || !bus.LDS_n);
   assign w_cnt_dec = (r_cnt != 3'd0) ? r_cnt - 3'd1 : r_cnt;

   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
         r_sel   <= 2'b00;
         r_rw    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
         r_rw    <= w_rw_nxt;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_rw_nxt    = r_rw;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_sel_nxt = bus.ADDR[13:12];
               w_rw_nxt  = bus.RW;
               if (bus.ADDR[16]) begin
                  w_state_nxt = S_SETUP;
                  w_cnt_nxt   = C_SETUP;
               end else begin
                  w_state_nxt = S_ROM;
               end
            end
         end
         S_SETUP: begin
            if (w_as_s) begin
               w_state_nxt = S_RECOVER;
               w_cnt_nxt   = C_RECOVER;
            end else if (r_cnt == 3'd0) begin
               w_state_nxt = S_ACTIVE;
               w_cnt_nxt   = C_ACTIVE;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_ACTIVE: begin
            // A released address strobe ends the pulse early but still honours recovery.
            if (w_as_s || r_cnt == 3'd0) begin
               w_state_nxt = S_RECOVER;
               w_cnt_nxt   = C_RECOVER;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_RECOVER: begin
            if (r_cnt == 3'd0) begin
               w_state_nxt = S_WAIT_AS;
            end else begin
               w_cnt_nxt = w_cnt_dec;
            end
         end
         S_ROM, S_WAIT_AS: begin
            if (w_as_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so they line up with it.
   always_comb begin
      w_ide1_cs_n = 2'b11;
      w_ide2_cs_n = 2'b11;
      w_cs_pat    = w_sel_nxt[0] ? 2'b01 : 2'b10;
      w_ior_n     = 1'b1;
      w_iow_n     = 1'b1;
      w_romen     = 1'b0;
      w_dtack     = r_dtack && !w_as_s;
      case (w_state_nxt)
         S_SETUP, S_ACTIVE, S_RECOVER: begin
            if (w_sel_nxt[1]) begin
               w_ide2_cs_n = w_cs_pat;
            end else begin
               w_ide1_cs_n = w_cs_pat;
            end
            if (w_state_nxt == S_ACTIVE) begin
               w_ior_n = !w_rw_nxt;
               w_iow_n = w_rw_nxt;
               if (w_cnt_nxt == 3'd0) begin
                  w_dtack = 1'b1;
               end
            end
         end
         S_ROM: begin
            w_romen = w_rw_nxt;
            if (r_state == S_ROM) begin
               w_dtack = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         r_ide1_cs_n <= 2'b11;
         r_ide2_cs_n <= 2'b11;
         r_ior_n     <= 1'b1;
         r_iow_n     <= 1'b1;
         r_romen     <= 1'b0;
         r_dtack     <= 1'b0;
      end else begin
         r_ide1_cs_n <= w_ide1_cs_n;
         r_ide2_cs_n <= w_ide2_cs_n;
         r_ior_n     <= w_ior_n;
         r_iow_n     <= w_iow_n;
         r_romen     <= w_romen;
         r_dtack     <= w_dtack;
      end
   end

   assign bus.IDE1_CS_n = r_ide1_cs_n;
   assign bus.IDE2_CS_n = r_ide2_cs_n;
   assign bus.IOR_n     = r_ior_n;
   assign bus.IOW_n     = r_iow_n;
   assign bus.IDE_ROMEN = r_romen;
   assign bus.DTACK     = r_dtack;
   assign bus.AS_n_S4   = r_as_s4;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Scoreboard bench for ide_pio_sequencer: two instances (default and slow timing) share stimulus;
// expected per-cycle outputs come from an interval model of each bus cycle.
module tb_ide_pio_sequencer;

   typedef struct packed {
      logic [1:0] cs1;
      logic [1:0] cs2;
      logic       ior;
      logic       iow;
      logic       romen;
      logic       dtack;
      logic       as4;
   } obs_t;

   typedef struct {
      obs_t  a;
      obs_t  b;
      string tag;
      int    j;
   } exp_t;

   localparam obs_t IDLE_OBS = '{cs1: 2'b11, cs2: 2'b11, ior: 1'b1, iow: 1'b1,
                                 romen: 1'b0, dtack: 1'b0, as4: 1'b1};
   localparam int NO_RST = 100000;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ide_access = 1'b0;
   logic        ide_enable = 1'b0;
   logic        as_n = 1'b1;
   logic        uds_n = 1'b1;
   logic        lds_n = 1'b1;
   logic        rw = 1'b1;
   logic [16:12] addr = '0;

   always #5 clk = ~clk;

   ide_pio_sequencer_if if_a ();
   ide_pio_sequencer_if if_b ();

   assign if_a.ide_access = ide_access;
   assign if_a.ide_enable = ide_enable;
   assign if_a.AS_n       = as_n;
   assign if_a.UDS_n      = uds_n;
   assign if_a.LDS_n      = lds_n;
   assign if_a.RW         = rw;
   assign if_a.ADDR       = addr;
   assign if_b.ide_access = ide_access;
   assign if_b.ide_enable = ide_enable;
   assign if_b.AS_n       = as_n;
   assign if_b.UDS_n      = uds_n;
   assign if_b.LDS_n      = lds_n;
   assign if_b.RW         = rw;
   assign if_b.ADDR       = addr;

   ide_pio_sequencer u_dut_a (
      .CLK     (clk),
      .RESET_n (rst_n),
      .bus     (if_a.slave)
   );

   ide_pio_sequencer #(
      .T_SETUP   (2),
      .T_ACTIVE  (5),
      .T_RECOVER (3)
   ) u_dut_b (
      .CLK     (clk),
      .RESET_n (rst_n),
      .bus     (if_b.slave)
   );

   obs_t got_a;
   obs_t got_b;
   assign got_a = {if_a.IDE1_CS_n, if_a.IDE2_CS_n, if_a.IOR_n, if_a.IOW_n,
                   if_a.IDE_ROMEN, if_a.DTACK, if_a.AS_n_S4};
   assign got_b = {if_b.IDE1_CS_n, if_b.IDE2_CS_n, if_b.IOR_n, if_b.IOW_n,
                   if_b.IDE_ROMEN, if_b.DTACK, if_b.AS_n_S4};

   // Expected outputs in the cycle after edge j of a bus cycle whose AS_n went low just after
   // edge 0 and stayed low for L edges. Start is taken at edge 3 (two sync flops + decision);
   // the first decision seeing AS_n high is edge L+3.
   function automatic obs_t model(input int j, input int ts, input int ta, input int tr,
                                  input bit start, input bit drv, input bit r_w,
                                  input logic [1:0] sel, input int L, input int rst_e);
      obs_t o;
      int   s;
      int   d;
      int   e;
      o = IDLE_OBS;
      s = 3;
      d = L + 3;
      if (j >= rst_e) return o;
      o.as4 = !(j >= 3 && j <= L + 2);
      if (!start) return o;
      if (drv) begin
         e = (d < s + ts + ta) ? d : s + ts + ta;
         if (j >= s && j <= e + tr - 1) begin
            if (sel[1]) o.cs2[sel[0]] = 1'b0;
            else        o.cs1[sel[0]] = 1'b0;
         end
         if (j >= s + ts && j < e) begin
            if (r_w) o.ior = 1'b0;
            else     o.iow = 1'b0;
         end
         if (d >= s + ts + ta && j >= s + ts + ta - 1 && j <= d - 1) o.dtack = 1'b1;
      end else begin
         if (j >= s && j < d) o.romen = r_w;
         if (j > s && j < d) o.dtack = 1'b1;
      end
      return o;
   endfunction

   task automatic check(input string who, input string tag, input int j,
                        input obs_t got, input obs_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s %s cycle %0d: got cs1=%b cs2=%b ior=%b iow=%b romen=%b dtack=%b as4=%b, expected cs1=%b cs2=%b ior=%b iow=%b romen=%b dtack=%b as4=%b",
                  who, tag, j, got.cs1, got.cs2, got.ior, got.iow, got.romen, got.dtack, got.as4,
                  exp.cs1, exp.cs2, exp.ior, exp.iow, exp.romen, exp.dtack, exp.as4);
      end
   endtask

   // Monitor: one expected entry per clock, compared mid-cycle on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dut_a", e.tag, e.j, got_a, e.a);
            check("dut_b", e.tag, e.j, got_b, e.b);
         end
      end
   end

   task automatic push_idle(input string tag);
      exp_t e;
      e.a   = IDLE_OBS;
      e.b   = IDLE_OBS;
      e.tag = tag;
      e.j   = 0;
      exp_q.push_back(e);
   endtask

   // Called 1 time unit after a rising edge; returns 1 time unit after the edge ending the window.
   task automatic run_txn(input string tag, input bit en, input bit acc, input bit uds,
                          input bit lds, input bit r_w, input logic [4:0] a,
                          input int L, input int rst_e);
      bit   start;
      int   w;
      exp_t e;
      start = en && acc && (!uds || !lds);
      w     = L + 26;
      for (int j = 0; j < w; j++) begin
         e.a   = model(j, 1, 3, 1, start, a[4], r_w, a[1:0], L, rst_e);
         e.b   = model(j, 2, 5, 3, start, a[4], r_w, a[1:0], L, rst_e);
         e.tag = tag;
         e.j   = j;
         exp_q.push_back(e);
      end
      ide_enable = en;
      ide_access = acc;
      uds_n      = uds;
      lds_n      = lds;
      rw         = r_w;
      addr       = a;
      as_n       = 1'b0;
      for (int j = 1; j < w; j++) begin
         @(posedge clk);
         #1;
         if (j == L) as_n = 1'b1;
         if (j == rst_e - 1) rst_n = 1'b0;
         if (j == rst_e) rst_n = 1'b1;
         // Once a cycle has started, the latched address/direction must not follow the bus.
         if (j == 4 && start) begin
            addr       = 5'($urandom);
            rw         = 1'($urandom);
            ide_enable = 1'($urandom);
            uds_n      = 1'($urandom);
            lds_n      = 1'($urandom);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         push_idle("reset");
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;

      run_txn("read_ide1_cs0",   1, 1, 0, 0, 1, 5'b10000, 12, NO_RST);
      run_txn("write_ide2_cs1",  1, 1, 0, 1, 0, 5'b10011, 14, NO_RST);
      run_txn("rom_read",        1, 1, 1, 0, 1, 5'b00000,  8, NO_RST);
      run_txn("rom_write",       1, 1, 0, 1, 0, 5'b01010,  6, NO_RST);
      run_txn("abort_setup",     1, 1, 0, 0, 1, 5'b10001,  1, NO_RST);
      run_txn("abort_active",    1, 1, 0, 0, 0, 5'b10010,  3, NO_RST);
      run_txn("dtack_one_cycle", 1, 1, 0, 0, 1, 5'b10000,  4, NO_RST);
      run_txn("disabled",        0, 1, 0, 0, 1, 5'b10000, 20, NO_RST);
      run_txn("no_data_strobe",  1, 1, 1, 1, 1, 5'b10000, 10, NO_RST);
      run_txn("no_access",       1, 0, 0, 0, 1, 5'b10001, 10, NO_RST);
      run_txn("reset_in_active", 1, 1, 0, 0, 1, 5'b10000,  5, 6);
      run_txn("after_reset",     1, 1, 0, 0, 1, 5'b11001,  9, NO_RST);

      for (int t = 0; t < 40; t++) begin
         run_txn($sformatf("rand%0d", t),
                 ($urandom % 8) != 0, ($urandom % 8) != 0,
                 ($urandom % 4) == 0, ($urandom % 4) == 0, 1'($urandom),
                 5'($urandom), 1 + int'($urandom % 16), NO_RST);
      end

      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
